// File: rtl/imu_sample_sequencer.sv
// imu_sample_sequencer: averages raw accelerometer/gyro samples once per
// filter period, converts them to Q2.14 small-angle tilt estimates and
// launches the Kalman attitude core, tracking missed and starved periods.
module imu_sample_sequencer #(
  parameter int unsigned CLK_DIV    = 5000000,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned ACC_G_LOG2 = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sens_valid,
  output logic               sens_ready,
  input  logic signed [15:0] acc_x,
  input  logic signed [15:0] acc_y,
  input  logic signed [15:0] gyro,
  output logic signed [15:0] theta_acc,
  output logic signed [15:0] phi_acc,
  output logic signed [15:0] gyro_u,
  output logic               kal_start,
  input  logic               kal_finish,
  output logic               busy,
  output logic [7:0]         overrun_cnt,
  output logic [7:0]         underrun_cnt
);

  localparam int unsigned N      = 1 << AVG_LOG2;
  localparam int unsigned ACC_W  = 16 + AVG_LOG2;
  localparam int unsigned SCNT_W = AVG_LOG2 + 1;
  localparam int unsigned TMR_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned LSH    = 14 - ACC_G_LOG2;
  localparam int unsigned CW     = 24;

  localparam logic signed [CW-1:0] SAT_MAX = CW'(32767);
  localparam logic signed [CW-1:0] SAT_MIN = -CW'(32768);

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_CONVERT,
    ST_LAUNCH,
    ST_WAIT_KF
  } state_e;

  state_e                    state_q, state_d;
  logic [TMR_W-1:0]          tmr_q, tmr_d;
  logic signed [ACC_W-1:0]   acc_x_q, acc_x_d;
  logic signed [ACC_W-1:0]   acc_y_q, acc_y_d;
  logic signed [ACC_W-1:0]   acc_g_q, acc_g_d;
  logic [SCNT_W-1:0]         scnt_q, scnt_d;
  logic                      fin_q, fin_d;
  logic signed [15:0]        theta_q, theta_d;
  logic signed [15:0]        phi_q, phi_d;
  logic signed [15:0]        gyro_u_q, gyro_u_d;
  logic                      kal_start_q, kal_start_d;
  logic                      busy_q, busy_d;
  logic [7:0]                ovr_q, ovr_d;
  logic [7:0]                und_q, und_d;

  logic                      tick;
  logic                      accept;
  logic                      fin_rise;
  logic                      full_eff;
  logic [SCNT_W-1:0]         scnt_eff;
  logic signed [ACC_W-1:0]   avg_x, avg_y, avg_g;
  logic signed [CW-1:0]      avg_x_w, avg_y_w;
  logic signed [CW-1:0]      theta_w, phi_w;

  // Clamp a wide signed value into the 16-bit signed range.
  function automatic logic signed [15:0] sat16(input logic signed [CW-1:0] v);
    if (v > SAT_MAX) begin
      return 16'sh7fff;
    end else if (v < SAT_MIN) begin
      return -16'sh8000;
    end else begin
      return 16'(v);
    end
  endfunction

  // Saturating 8-bit increment for the event counters.
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hff) ? c : c + 8'd1;
  endfunction

  // Sample handshake: blocked during conversion and once N samples are held.
  assign sens_ready = !reset && (state_q != ST_CONVERT) && (scnt_q < SCNT_W'(N));
  assign accept     = sens_valid && sens_ready;
  assign fin_rise   = kal_finish && !fin_q;
  assign fin_d      = kal_finish;

  // Free-running period timer; runs in every state.
  always_comb begin
    tick  = (tmr_q == TMR_W'(CLK_DIV - 1));
    tmr_d = tick ? '0 : tmr_q + TMR_W'(1);
  end

  // Sample count including a sample accepted this very cycle.
  always_comb begin
    scnt_eff = scnt_q + SCNT_W'(accept);
    full_eff = (scnt_eff == SCNT_W'(N));
  end

  // Averages and Q2.14 angle scaling; the wide intermediates keep -(-32768) exact.
  always_comb begin
    avg_x   = acc_x_q >>> AVG_LOG2;
    avg_y   = acc_y_q >>> AVG_LOG2;
    avg_g   = acc_g_q >>> AVG_LOG2;
    avg_x_w = CW'(avg_x);
    avg_y_w = CW'(avg_y);
    theta_w = (-avg_x_w) <<< LSH;
    phi_w   = avg_y_w <<< LSH;
  end

  // Sequencer next-state, accumulation and registered-output logic.
  always_comb begin
    state_d  = state_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    acc_g_d  = acc_g_q;
    scnt_d   = scnt_q;
    theta_d  = theta_q;
    phi_d    = phi_q;
    gyro_u_d = gyro_u_q;
    ovr_d    = ovr_q;
    und_d    = und_q;

    if (accept) begin
      acc_x_d = acc_x_q + ACC_W'(acc_x);
      acc_y_d = acc_y_q + ACC_W'(acc_y);
      acc_g_d = acc_g_q + ACC_W'(gyro);
      scnt_d  = scnt_eff;
    end

    case (state_q)
      ST_ACCUM: begin
        if (tick) begin
          if (full_eff) begin
            state_d = ST_CONVERT;
          end else begin
            und_d = sat_inc(und_q);
          end
        end
      end
      ST_CONVERT: begin
        theta_d  = sat16(theta_w);
        phi_d    = sat16(phi_w);
        gyro_u_d = 16'(avg_g);
        acc_x_d  = '0;
        acc_y_d  = '0;
        acc_g_d  = '0;
        scnt_d   = '0;
        state_d  = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_KF;
      end
      ST_WAIT_KF: begin
        // A finish edge coinciding with a tick is judged as if already in ACCUM.
        if (fin_rise) begin
          if (tick && full_eff) begin
            state_d = ST_CONVERT;
          end else begin
            state_d = ST_ACCUM;
            if (tick) begin
              und_d = sat_inc(und_q);
            end
          end
        end else if (tick) begin
          ovr_d = sat_inc(ovr_q);
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase

    kal_start_d = (state_d == ST_LAUNCH);
    busy_d      = (state_d != ST_ACCUM);
  end

  // State and datapath registers; finish history resets high to mask a held level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ACCUM;
      tmr_q       <= '0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      acc_g_q     <= '0;
      scnt_q      <= '0;
      fin_q       <= 1'b1;
      theta_q     <= '0;
      phi_q       <= '0;
      gyro_u_q    <= '0;
      kal_start_q <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= '0;
      und_q       <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      acc_g_q     <= acc_g_d;
      scnt_q      <= scnt_d;
      fin_q       <= fin_d;
      theta_q     <= theta_d;
      phi_q       <= phi_d;
      gyro_u_q    <= gyro_u_d;
      kal_start_q <= kal_start_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
      und_q       <= und_d;
    end
  end

  assign theta_acc    = theta_q;
  assign phi_acc      = phi_q;
  assign gyro_u       = gyro_u_q;
  assign kal_start    = kal_start_q;
  assign busy         = busy_q;
  assign overrun_cnt  = ovr_q;
  assign underrun_cnt = und_q;

endmodule

// File: tb/tb_imu_sample_sequencer.sv
// Directed bench for imu_sample_sequencer with CLK_DIV=64, AVG_LOG2=2, ACC_G_LOG2=12.
module tb_imu_sample_sequencer;

  localparam int unsigned CLK_DIV    = 64;
  localparam int unsigned AVG_LOG2   = 2;
  localparam int unsigned ACC_G_LOG2 = 12;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               sens_valid = 1'b0;
  logic               sens_ready;
  logic signed [15:0] acc_x = '0;
  logic signed [15:0] acc_y = '0;
  logic signed [15:0] gyro = '0;
  logic signed [15:0] theta_acc;
  logic signed [15:0] phi_acc;
  logic signed [15:0] gyro_u;
  logic               kal_start;
  logic               kal_finish = 1'b0;
  logic               busy;
  logic [7:0]         overrun_cnt;
  logic [7:0]         underrun_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ks_cnt = 0;
  int ks_last = -1;
  logic signed [15:0] sx[4];
  logic signed [15:0] sy[4];
  logic signed [15:0] sg[4];

  always #5 clk = ~clk;

  imu_sample_sequencer #(
    .CLK_DIV(CLK_DIV), .AVG_LOG2(AVG_LOG2), .ACC_G_LOG2(ACC_G_LOG2)
  ) dut (
    .clk(clk), .reset(reset), .sens_valid(sens_valid), .sens_ready(sens_ready),
    .acc_x(acc_x), .acc_y(acc_y), .gyro(gyro),
    .theta_acc(theta_acc), .phi_acc(phi_acc), .gyro_u(gyro_u),
    .kal_start(kal_start), .kal_finish(kal_finish), .busy(busy),
    .overrun_cnt(overrun_cnt), .underrun_cnt(underrun_cnt)
  );

  // Advance one cycle; outputs are observed on the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (kal_start === 1'b1) begin
      ks_cnt++;
      ks_last = cyc;
    end
  endtask

  task automatic wait_cycle(input int n);
    while (cyc < n) step();
  endtask

  task automatic release_reset();
    reset = 1'b0;
    cyc = 0;
    ks_cnt = 0;
    ks_last = -1;
  endtask

  task automatic send(input int x, input int y, input int g);
    sens_valid = 1'b1;
    acc_x = 16'(x);
    acc_y = 16'(y);
    gyro = 16'(g);
    step();
    sens_valid = 1'b0;
  endtask

  task automatic set_samples(input int x0, input int x1, input int x2, input int x3,
                             input int y0, input int y1, input int y2, input int y3,
                             input int g0, input int g1, input int g2, input int g3);
    sx[0] = 16'(x0); sx[1] = 16'(x1); sx[2] = 16'(x2); sx[3] = 16'(x3);
    sy[0] = 16'(y0); sy[1] = 16'(y1); sy[2] = 16'(y2); sy[3] = 16'(y3);
    sg[0] = 16'(g0); sg[1] = 16'(g1); sg[2] = 16'(g2); sg[3] = 16'(g3);
  endtask

  // Feed four samples, let the period launch, answer with a finish 10 cycles later.
  task automatic launch_period(output int p);
    p = cyc / 64;
    for (int i = 0; i < 4; i++) send(int'(sx[i]), int'(sy[i]), int'(sg[i]));
    wait_cycle(64 * p + 75);
    kal_finish = 1'b1;
    step();
    kal_finish = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({theta_acc, phi_acc, gyro_u, overrun_cnt, underrun_cnt, kal_start, busy, sens_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0",
               {theta_acc, phi_acc, gyro_u, overrun_cnt, underrun_cnt, kal_start, busy, sens_ready});
    end
    release_reset();
    #1;
    checks++;
    if (sens_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_release: got %b required 1", sens_ready);
    end
    wait_cycle(63);
    checks++;
    if (underrun_cnt !== 8'd0) begin
      failures++;
      $display("FAIL underrun_before_tick: got %0d required 0", underrun_cnt);
    end
    wait_cycle(64);
    checks++;
    if (underrun_cnt !== 8'd1) begin
      failures++;
      $display("FAIL underrun_first_tick: got %0d required 1", underrun_cnt);
    end
    checks++;
    if (busy !== 1'b0 || ks_cnt !== 0) begin
      failures++;
      $display("FAIL no_launch_empty: busy %b starts %0d required 0 0", busy, ks_cnt);
    end
  endtask

  task automatic test_basic();
    int ks0;
    for (int i = 0; i < 4; i++) send(-1024, 2048, 100);
    checks++;
    if (sens_ready !== 1'b0) begin
      failures++;
      $display("FAIL fifth_blocked: ready %b required 0", sens_ready);
    end
    ks0 = ks_cnt;
    for (int i = 0; i < 3; i++) send(5000, 5000, 5000);
    wait_cycle(128);
    checks++;
    if (busy !== 1'b1 || sens_ready !== 1'b0 || kal_start !== 1'b0) begin
      failures++;
      $display("FAIL convert_cycle: busy %b ready %b start %b required 1 0 0", busy, sens_ready, kal_start);
    end
    wait_cycle(129);
    checks++;
    if (kal_start !== 1'b1) begin
      failures++;
      $display("FAIL start_at_t2: got %b required 1", kal_start);
    end
    checks++;
    if (int'(theta_acc) !== 4096 || int'(phi_acc) !== 8192 || int'(gyro_u) !== 100) begin
      failures++;
      $display("FAIL basic_outputs: got %0d %0d %0d required 4096 8192 100",
               theta_acc, phi_acc, gyro_u);
    end
    wait_cycle(135);
    checks++;
    if (ks_cnt - ks0 !== 1 || busy !== 1'b1 || int'(theta_acc) !== 4096) begin
      failures++;
      $display("FAIL single_pulse_hold: pulses %0d busy %b theta %0d required 1 1 4096",
               ks_cnt - ks0, busy, theta_acc);
    end
    wait_cycle(139);
    kal_finish = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL finish_exit: busy %b required 0", busy);
    end
    kal_finish = 1'b0;
    step();
  endtask

  task automatic test_average_sat();
    int p;
    int et, ep, eg;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin set_samples(1, 2, 3, 5, 0, 0, 0, 0, -3, 0, 0, 0); et = -8; ep = 0; eg = -1; end
        1: begin set_samples(-1, -1, -1, -2, 7, 7, 7, 7, 4, 4, 4, 4); et = 8; ep = 28; eg = 4; end
        2: begin set_samples(0, 0, 0, 0, 10000, 10000, 10000, 10000, -32768, -32768, -32768, -32768);
                 et = 0; ep = 32767; eg = -32768; end
        3: begin set_samples(-32768, -32768, -32768, -32768, -8192, -8192, -8192, -8192, 0, 0, 0, 0);
                 et = 32767; ep = -32768; eg = 0; end
        default: begin set_samples(20000, 20000, 20000, 20000, -10000, -10000, -10000, -10000,
                                   32767, 32767, 32767, 32767); et = -32768; ep = -32768; eg = 32767; end
      endcase
      launch_period(p);
      checks++;
      if (int'(theta_acc) !== et || int'(phi_acc) !== ep || int'(gyro_u) !== eg || ks_last !== 64 * p + 65) begin
        failures++;
        $display("FAIL avg_case%0d: got %0d %0d %0d start@%0d required %0d %0d %0d start@%0d",
                 k, theta_acc, phi_acc, gyro_u, ks_last, et, ep, eg, 64 * p + 65);
      end
    end
  endtask

  task automatic test_overrun();
    int b;
    b = 64 * (cyc / 64);
    for (int i = 0; i < 4; i++) send(512, 0, 0);
    wait_cycle(b + 65);
    checks++;
    if (ks_last !== b + 65 || int'(theta_acc) !== -2048) begin
      failures++;
      $display("FAIL ovr_launch: start@%0d theta %0d required %0d -2048", ks_last, theta_acc, b + 65);
    end
    wait_cycle(b + 72);
    for (int i = 0; i < 4; i++) send(-2048, 0, 0);
    checks++;
    if (sens_ready !== 1'b0) begin
      failures++;
      $display("FAIL wait_saturated: ready %b required 0", sens_ready);
    end
    wait_cycle(b + 128);
    checks++;
    if (overrun_cnt !== 8'd1 || busy !== 1'b1 || ks_last !== b + 65 || int'(theta_acc) !== -2048) begin
      failures++;
      $display("FAIL overrun_one: ovr %0d busy %b start@%0d theta %0d required 1 1 %0d -2048",
               overrun_cnt, busy, ks_last, theta_acc, b + 65);
    end
    wait_cycle(b + 132);
    kal_finish = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL late_finish_exit: busy %b required 0", busy);
    end
    wait_cycle(b + 193);
    checks++;
    if (ks_last !== b + 193 || int'(theta_acc) !== 8192) begin
      failures++;
      $display("FAIL held_samples_launch: start@%0d theta %0d required %0d 8192", ks_last, theta_acc, b + 193);
    end
    wait_cycle(b + 230);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL level_no_exit: busy %b required 1", busy);
    end
    wait_cycle(b + 256);
    checks++;
    if (overrun_cnt !== 8'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL overrun_two: ovr %0d busy %b required 2 1", overrun_cnt, busy);
    end
    wait_cycle(b + 258);
    kal_finish = 1'b0;
    wait_cycle(b + 260);
    kal_finish = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || underrun_cnt !== 8'd1) begin
      failures++;
      $display("FAIL toggle_exit: busy %b und %0d required 0 1", busy, underrun_cnt);
    end
    kal_finish = 1'b0;
    step();
  endtask

  task automatic test_finish_tick_same_cycle();
    int b;
    b = 64 * (cyc / 64);
    for (int i = 0; i < 4; i++) send(1024, 0, 0);
    wait_cycle(b + 65);
    checks++;
    if (ks_last !== b + 65 || int'(theta_acc) !== -4096) begin
      failures++;
      $display("FAIL sc_launch: start@%0d theta %0d required %0d -4096", ks_last, theta_acc, b + 65);
    end
    wait_cycle(b + 70);
    for (int i = 0; i < 3; i++) send(-512, 0, 40);
    wait_cycle(b + 127);
    sens_valid = 1'b1;
    acc_x = -16'sd512;
    acc_y = '0;
    gyro = 16'sd40;
    kal_finish = 1'b1;
    step();
    sens_valid = 1'b0;
    kal_finish = 1'b0;
    checks++;
    if (busy !== 1'b1 || sens_ready !== 1'b0 || overrun_cnt !== 8'd2) begin
      failures++;
      $display("FAIL sc_direct_convert: busy %b ready %b ovr %0d required 1 0 2", busy, sens_ready, overrun_cnt);
    end
    step();
    checks++;
    if (kal_start !== 1'b1 || int'(theta_acc) !== 2048 || int'(gyro_u) !== 40 || underrun_cnt !== 8'd1) begin
      failures++;
      $display("FAIL sc_launch_full: start %b theta %0d gyro %0d und %0d required 1 2048 40 1",
               kal_start, theta_acc, gyro_u, underrun_cnt);
    end
    wait_cycle(b + 140);
    for (int i = 0; i < 3; i++) send(100, 0, 0);
    wait_cycle(b + 191);
    kal_finish = 1'b1;
    step();
    kal_finish = 1'b0;
    checks++;
    if (busy !== 1'b0 || underrun_cnt !== 8'd2) begin
      failures++;
      $display("FAIL sc_short_underrun: busy %b und %0d required 0 2", busy, underrun_cnt);
    end
    step();
    checks++;
    if (ks_last !== b + 129 || int'(theta_acc) !== 2048 || overrun_cnt !== 8'd2) begin
      failures++;
      $display("FAIL sc_short_no_launch: start@%0d theta %0d ovr %0d required %0d 2048 2",
               ks_last, theta_acc, overrun_cnt, b + 129);
    end
  endtask

  task automatic test_reset_mid();
    int b;
    b = 64 * (cyc / 64);
    send(100, 0, 0);
    wait_cycle(b + 65);
    checks++;
    if (ks_last !== b + 65 || int'(theta_acc) !== -400) begin
      failures++;
      $display("FAIL carry_launch: start@%0d theta %0d required %0d -400", ks_last, theta_acc, b + 65);
    end
    wait_cycle(b + 69);
    reset = 1'b1;
    #1;
    checks++;
    if ({theta_acc, phi_acc, gyro_u, overrun_cnt, underrun_cnt, kal_start, busy, sens_ready} !== '0) begin
      failures++;
      $display("FAIL reset_in_wait: got %h required 0",
               {theta_acc, phi_acc, gyro_u, overrun_cnt, underrun_cnt, kal_start, busy, sens_ready});
    end
    step();
    release_reset();
    #1;
    checks++;
    if (sens_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_rerelease: got %b required 1", sens_ready);
    end
    wait_cycle(63);
    checks++;
    if (underrun_cnt !== 8'd0) begin
      failures++;
      $display("FAIL restart_before_tick: und %0d required 0", underrun_cnt);
    end
    wait_cycle(64);
    checks++;
    if (underrun_cnt !== 8'd1 || ks_cnt !== 0) begin
      failures++;
      $display("FAIL restart_first_tick: und %0d starts %0d required 1 0", underrun_cnt, ks_cnt);
    end
    for (int i = 0; i < 4; i++) send(-1024, 0, 0);
    wait_cycle(129);
    checks++;
    if (kal_start !== 1'b1 || int'(theta_acc) !== 4096) begin
      failures++;
      $display("FAIL pre_reset_launch: start %b theta %0d required 1 4096", kal_start, theta_acc);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (kal_start !== 1'b0 || int'(theta_acc) !== 0 || underrun_cnt !== 8'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_launch: start %b theta %0d und %0d busy %b required 0 0 0 0",
               kal_start, theta_acc, underrun_cnt, busy);
    end
    step();
    release_reset();
    for (int i = 0; i < 4; i++) send(256, 0, 0);
    wait_cycle(65);
    checks++;
    if (kal_start !== 1'b1 || int'(theta_acc) !== -1024 || underrun_cnt !== 8'd0) begin
      failures++;
      $display("FAIL clean_restart: start %b theta %0d und %0d required 1 -1024 0",
               kal_start, theta_acc, underrun_cnt);
    end
    wait_cycle(75);
    kal_finish = 1'b1;
    step();
    kal_finish = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_average_sat();
    test_overrun();
    test_finish_tick_same_cycle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imu_sample_sequencer.md
# imu_sample_sequencer

Upstream front end of the Kalman attitude core. Accepts raw accelerometer and gyro samples over a valid/ready stream and averages 2^AVG_LOG2 of them per filter period. Converts the averages to small-angle tilt estimates in Q2.14 (theta_acc, phi_acc) plus a gyro input. Once per period it pulses kal_start and waits for kal_finish, counting missed and overrun periods.

## Interface
Parameters:
- CLK_DIV, 5000000, filter period in clk cycles (0.1 s at 50 MHz); legal range ≥ 8
- AVG_LOG2, 2, log2 of the number of samples averaged per period; legal range 0..4
- ACC_G_LOG2, 12, raw accelerometer counts per 1 g are 2^ACC_G_LOG2; legal range 10..14

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- sens_valid  in  1  sample present on acc_x/acc_y/gyro
- sens_ready  out  1  sample accepted when sens_valid && sens_ready
- acc_x  in  16  signed raw X acceleration
- acc_y  in  16  signed raw Y acceleration
- gyro  in  16  signed gyro rate, already Q2.14, not rescaled
- theta_acc  out  16  signed Q2.14 pitch estimate
- phi_acc  out  16  signed Q2.14 roll estimate
- gyro_u  out  16  signed averaged gyro rate
- kal_start  out  1  one-cycle launch pulse to the Kalman core
- kal_finish  in  1  Kalman done; only its rising edge is used
- busy  out  1  high in CONVERT, LAUNCH and WAIT_KF
- overrun_cnt  out  8  saturating count of periods the core missed
- underrun_cnt  out  8  saturating count of periods with insufficient samples

## Operation
- Period timer: free-running 0..CLK_DIV-1. tick = (count == CLK_DIV-1). It runs in every state. The first tick occurs at cycle CLK_DIV-1 after reset release.
- Accumulators: three signed (16+AVG_LOG2)-bit accumulators (x, y, g) and a sample counter scnt in 0..N, where N = 2^AVG_LOG2.
- On each accepted sample, all three accumulators add the sign-extended sample and scnt increments.
- sens_ready = !reset && state != CONVERT && scnt < N.
- States:
  - ACCUM: on tick, evaluate scnt including any sample accepted in the same cycle. If scnt == N, go to CONVERT. Otherwise increment underrun_cnt and stay.
  - CONVERT (1 cycle): compute avg = acc >>> AVG_LOG2 (arithmetic shift, rounds toward −∞). Register theta_acc = sat16((−avg_x) <<< (14−ACC_G_LOG2)), phi_acc = sat16(avg_y <<< (14−ACC_G_LOG2)) and gyro_u = avg_g. Clear the accumulators and scnt. Go to LAUNCH.
  - LAUNCH (1 cycle): kal_start = 1. Go to WAIT_KF. Accumulation is enabled.
  - WAIT_KF: accumulation continues. On a kal_finish rising edge, go to ACCUM; a tick in the same cycle is evaluated under the ACCUM rule, so go to CONVERT if scnt == N, otherwise increment underrun_cnt. On a tick without a finish edge, increment overrun_cnt and stay in WAIT_KF; that period's samples keep accumulating, saturated at N.
- sat16 clamps to [−32768, 32767]. Negation and shift use ≥ 20-bit intermediates, so −(−32768) does not wrap.
- Both counters saturate at 255 and are cleared only by reset.
- kal_finish edge detect uses a registered copy reset to 1, so a level held high through reset does not produce a spurious edge.

## Timing
- Reset values: state ACCUM, theta_acc/phi_acc/gyro_u = 0, kal_start = 0, busy = 0, both counters 0, timer 0, accumulators 0, scnt 0. sens_ready is 0 while reset is asserted and 1 in the first cycle after release.
- Tick at cycle T with enough samples: CONVERT at T+1; outputs valid from T+2; kal_start high exactly at T+2; WAIT_KF from T+3.
- theta_acc, phi_acc and gyro_u change only at the end of CONVERT. They are held stable through the whole WAIT_KF.
- Sample throughput in ACCUM, LAUNCH and WAIT_KF is one per cycle. Zero samples are accepted in CONVERT.
- Reset mid-operation (any state) aborts immediately: all registers return to reset values and kal_start deasserts asynchronously.

## Test plan
Parameters for all scenarios: CLK_DIV=64, AVG_LOG2=2, ACC_G_LOG2=12. The Kalman core model raises kal_finish 10 cycles after kal_start.
- Reset release: all outputs 0, sens_ready=1 next cycle, first tick at cycle 63, then underrun_cnt=1 with no kal_start since no samples were sent.
- Four samples acc_x=−1024, acc_y=2048, gyro=100: theta_acc=4096, phi_acc=8192, gyro_u=100; kal_start is a single pulse 2 cycles after tick; 5th sample blocked (sens_ready=0).
- Averaging and saturation: acc_x samples {1,2,3,5} give theta_acc=−8; {−1,−1,−1,−2} give theta_acc=8; acc_y=10000×4 gives phi_acc=32767; acc_x=−32768×4 gives theta_acc=32767; acc_x=20000×4 gives theta_acc=−32768.
- Overrun: hold kal_finish low across the next tick, giving overrun_cnt=1 with no kal_start. Raise kal_finish with 4 samples present: ACCUM, and the next tick launches. Also hold kal_finish high continuously: no second exit until it toggles.
- Finish edge and tick in the same cycle with scnt=4: direct transition to CONVERT, kal_start 2 cycles later, no counter change. Repeat with scnt=3: underrun_cnt increments and the state is ACCUM.
- Assert reset during WAIT_KF and again one cycle after CONVERT: outputs and counters are 0 immediately, and the sequence restarts cleanly with the first tick at cycle 63.
